// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router packet FIFO.
package router_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int LEN_MSB_DEF = 7;
    localparam int LEN_LSB_DEF = 2;
    localparam int TAG_BIT     = DATA_W_DEF;

    // Address width for a given depth, never below 1 bit.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Tagged word storage: one synchronous write port, one asynchronous read port, no reset.
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware destination FIFO: pointers, occupancy flags, header counting and
// read-side framing that discards words popped outside a packet.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int LEN_MSB  = LEN_MSB_DEF,
    parameter int LEN_LSB  = LEN_LSB_DEF,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2_safe(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       occupancy,
    output logic [AW:0]       pkt_count,
    output logic              orphan_err
);

    localparam int RW = LEN_MSB - LEN_LSB + 2;

    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [RW-1:0]   remaining;
    logic            lfd_d;
    logic [DATA_W:0] rd_word;
    logic            wr_acc;
    logic            rd_acc;
    logic            rd_hdr;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign occupancy    = wr_ptr - rd_ptr;
    assign almost_full  = (occupancy >= (AW+1)'(AF_LEVEL));
    assign almost_empty = (occupancy <= (AW+1)'(AE_LEVEL));

    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;
    assign rd_hdr = rd_word[DATA_W];

    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (wr_acc & ~soft_reset),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({lfd_d, data_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lfd_d     <= 1'b0;
            pkt_count <= '0;
        end else if (soft_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lfd_d     <= 1'b0;
            pkt_count <= '0;
        end else begin
            lfd_d <= lfd_state;
            if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_acc) rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({wr_acc & lfd_d, rd_acc & rd_hdr})
                2'b10:   pkt_count <= pkt_count + (AW+1)'(1);
                2'b01:   pkt_count <= pkt_count - (AW+1)'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Header load counts the parity word too, hence the +1 on the length field.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            orphan_err <= 1'b0;
            remaining  <= '0;
        end else if (soft_reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            orphan_err <= 1'b0;
            remaining  <= '0;
        end else begin
            data_valid <= 1'b0;
            orphan_err <= 1'b0;
            if (rd_acc) begin
                if (rd_hdr) begin
                    data_out   <= rd_word[DATA_W-1:0];
                    remaining  <= RW'(rd_word[LEN_MSB:LEN_LSB]) + RW'(1);
                    data_valid <= 1'b1;
                end else if (remaining != '0) begin
                    data_out   <= rd_word[DATA_W-1:0];
                    remaining  <= remaining - RW'(1);
                    data_valid <= 1'b1;
                end else begin
                    orphan_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: framing, full/empty limits, flags, flush and wrap.
module tb_router_pkt_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_en;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] occupancy;
    logic [4:0] pkt_count;
    logic       orphan_err;

    int checks = 0;
    int errors = 0;

    router_pkt_fifo dut (
        .clock        (clock),
        .resetn       (resetn),
        .soft_reset   (soft_reset),
        .write_en     (write_en),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .read_en      (read_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .occupancy    (occupancy),
        .pkt_count    (pkt_count),
        .orphan_err   (orphan_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        write_en = 1'b1;
        data_in  = d;
        tick();
        write_en = 1'b0;
    endtask

    // lfd_state leads the header write by one cycle.
    task automatic wr_hdr(input logic [7:0] d);
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
        wr(d);
    endtask

    task automatic rd();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
    endtask

    logic [7:0] pkt1 [6];
    logic [7:0] exp_d;

    initial begin
        resetn = 1'b0; soft_reset = 1'b0; write_en = 1'b0; lfd_state = 1'b0;
        data_in = '0; read_en = 1'b0;
        #12;
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_almost_empty", almost_empty, 1'b1);
        check("rst_occupancy", occupancy, 5'd0);
        check("rst_pkt_count", pkt_count, 5'd0);
        check("rst_orphan_err", orphan_err, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // 1: header len 4, 4 payload, parity
        pkt1[0] = 8'h10; pkt1[1] = 8'h11; pkt1[2] = 8'h22;
        pkt1[3] = 8'h33; pkt1[4] = 8'h44; pkt1[5] = 8'h5A;
        wr_hdr(pkt1[0]);
        check("t1_pkt_count_hdr", pkt_count, 5'd1);
        for (int i = 1; i < 6; i++) wr(pkt1[i]);
        check("t1_occupancy", occupancy, 5'd6);
        for (int i = 0; i < 6; i++) begin
            rd();
            check($sformatf("t1_data_%0d", i), data_out, pkt1[i]);
            check($sformatf("t1_valid_%0d", i), data_valid, 1'b1);
            if (i == 0) check("t1_pkt_count_pop", pkt_count, 5'd0);
        end
        check("t1_empty", empty, 1'b1);
        tick();
        check("t1_valid_idle", data_valid, 1'b0);
        check("t1_data_hold", data_out, 8'h5A);

        // 2: fill to full, drop 17th write, drain
        wr_hdr(8'h38);
        for (int i = 1; i < 16; i++) wr(8'h60 + 8'(i));
        check("t2_full", full, 1'b1);
        check("t2_occupancy", occupancy, 5'd16);
        wr(8'hAA);
        check("t2_occ_after_drop", occupancy, 5'd16);
        for (int i = 0; i < 16; i++) begin
            rd();
            exp_d = (i == 0) ? 8'h38 : 8'h60 + 8'(i);
            check($sformatf("t2_data_%0d", i), data_out, exp_d);
        end
        check("t2_empty", empty, 1'b1);

        // 3: read and write together while full
        wr_hdr(8'h38);
        for (int i = 1; i < 16; i++) wr(8'h80 + 8'(i));
        check("t3_full", full, 1'b1);
        read_en = 1'b1; write_en = 1'b1; data_in = 8'h77;
        check("t3_occ_before", occupancy, 5'd16);
        tick();
        read_en = 1'b0; write_en = 1'b0;
        check("t3_data", data_out, 8'h38);
        check("t3_valid", data_valid, 1'b1);
        check("t3_occ_after", occupancy, 5'd15);
        for (int i = 0; i < 15; i++) rd();
        check("t3_last_data", data_out, 8'h8F);
        check("t3_empty", empty, 1'b1);

        // 4: orphan word
        wr(8'h55);
        rd();
        check("t4_orphan", orphan_err, 1'b1);
        check("t4_valid", data_valid, 1'b0);
        check("t4_data_hold", data_out, 8'h8F);
        check("t4_empty", empty, 1'b1);
        tick();
        check("t4_orphan_pulse", orphan_err, 1'b0);

        // 5: soft reset mid-packet
        wr_hdr(8'h20);
        for (int i = 1; i < 6; i++) wr(8'hA0 + 8'(i));
        rd(); rd(); rd();
        check("t5_data_pre", data_out, 8'hA2);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("t5_empty", empty, 1'b1);
        check("t5_occupancy", occupancy, 5'd0);
        check("t5_data_out", data_out, 8'h00);
        check("t5_pkt_count", pkt_count, 5'd0);
        wr(8'h66);
        rd();
        check("t5_orphan_after_flush", orphan_err, 1'b1);
        check("t5_data_after_orphan", data_out, 8'h00);
        wr_hdr(8'h04); wr(8'h71); wr(8'h72);
        rd();
        check("t5_new_hdr", data_out, 8'h04);
        check("t5_new_hdr_valid", data_valid, 1'b1);
        rd();
        check("t5_new_pay", data_out, 8'h71);
        rd();
        check("t5_new_par", data_out, 8'h72);
        check("t5_new_par_valid", data_valid, 1'b1);

        // 6: watermarks
        wr_hdr(8'h2C);
        for (int i = 1; i < 11; i++) wr(8'hC0 + 8'(i));
        check("t6_occ_11", occupancy, 5'd11);
        check("t6_af_11", almost_full, 1'b0);
        wr(8'hCB);
        check("t6_af_12", almost_full, 1'b1);
        for (int i = 0; i < 9; i++) rd();
        check("t6_occ_3", occupancy, 5'd3);
        check("t6_ae_3", almost_empty, 1'b0);
        check("t6_af_3", almost_full, 1'b0);
        rd();
        check("t6_occ_2", occupancy, 5'd2);
        check("t6_ae_2", almost_empty, 1'b1);
        rd(); rd();
        check("t6_last_data", data_out, 8'hCB);
        check("t6_last_valid", data_valid, 1'b1);

        // pointer wrap over three full/empty rounds
        for (int k = 0; k < 3; k++) begin
            wr_hdr(8'h38);
            for (int i = 1; i < 16; i++) wr(8'(16 * k + i));
            check($sformatf("wrap%0d_full", k), full, 1'b1);
            for (int i = 0; i < 16; i++) begin
                rd();
                exp_d = (i == 0) ? 8'h38 : 8'(16 * k + i);
                check($sformatf("wrap%0d_data_%0d", k, i), data_out, exp_d);
            end
            check($sformatf("wrap%0d_empty", k), empty, 1'b1);
        end

        // async reset mid-packet
        wr_hdr(8'h0C); wr(8'h01);
        #2 resetn = 1'b0;
        #2;
        check("mid_rst_occ", occupancy, 5'd0);
        check("mid_rst_pkt", pkt_count, 5'd0);
        check("mid_rst_data", data_out, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        wr(8'h02);
        rd();
        check("mid_rst_orphan", orphan_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
